// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: bursts a frame out of SDRAM into read_fifo and streams it through a 2-entry skid buffer
module sdram_frame_reader #(
    parameter int          BURST_LEN   = 256,
    parameter int          FRAME_WORDS = 76800,
    parameter logic [19:0] BASE_ADDR   = 20'h0,
    parameter int          FIFO_THRESH = 256
) (
    input  logic        S_CLK,
    input  logic        RST,
    input  logic        rd_enable,
    input  logic        frame_start,
    input  logic [1:0]  rd_bank,
    output logic        read_req,
    input  logic        read_ack,
    output logic [19:0] sdram_addr,
    output logic [1:0]  sys_bank,
    input  logic [8:0]  fifo_wrusedw,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    input  logic [15:0] fifo_q,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic [15:0] underrun_cnt
);
    localparam logic [19:0] LAST_ADDR = 20'(BASE_ADDR + FRAME_WORDS - BURST_LEN);
    localparam logic [19:0] STEP      = 20'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

    state_t      state;
    logic        settle_cnt;
    logic        restart_pend;
    logic [1:0]  bank_latch;
    logic [1:0]  cnt;
    logic        inflight;
    logic [15:0] spare;
    logic        started;
    logic        pop;
    logic [1:0]  slot;

    // Burst request FSM; a pending restart is only applied once back in IDLE so a running burst always completes
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            settle_cnt   <= 1'b0;
            restart_pend <= 1'b0;
            bank_latch   <= 2'd0;
            read_req     <= 1'b0;
            sdram_addr   <= BASE_ADDR;
            sys_bank     <= 2'd0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart_pend) begin
                        sdram_addr   <= BASE_ADDR;
                        sys_bank     <= bank_latch;
                        restart_pend <= 1'b0;
                    end else if (rd_enable && 32'(fifo_wrusedw) < FIFO_THRESH) begin
                        state    <= REQ;
                        read_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (read_ack) begin
                        read_req   <= 1'b0;
                        state      <= SETTLE;
                        settle_cnt <= 1'b0;
                        if (sdram_addr == LAST_ADDR) begin
                            sdram_addr <= BASE_ADDR;
                            sys_bank   <= rd_bank;
                            frame_done <= 1'b1;
                        end else begin
                            sdram_addr <= sdram_addr + STEP;
                        end
                    end
                end
                SETTLE: begin
                    settle_cnt <= 1'b1;
                    if (settle_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (frame_start) begin
                restart_pend <= 1'b1;
                bank_latch   <= rd_bank;
            end
        end
    end

    // Pop only while the skid entries plus the word in flight can never exceed two
    always_comb begin
        pop        = pix_valid & pix_ready;
        slot       = cnt - {1'b0, pop};
        fifo_rdreq = !RST && !fifo_rdempty && (slot + {1'b0, inflight}) < 2'd2;
    end

    assign pix_valid = |cnt;

    // Skid buffer: pix_data is the head entry, spare the second; arriving words land after any pop this cycle
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            pix_data <= 16'd0;
            spare    <= 16'd0;
        end else begin
            inflight <= fifo_rdreq;
            cnt      <= cnt + {1'b0, inflight} - {1'b0, pop};
            if (pop) pix_data <= spare;
            if (inflight && slot == 2'd0) pix_data <= fifo_q;
            if (inflight && slot == 2'd1) spare <= fifo_q;
        end
    end

    // Underrun counter only starts once the consumer has taken its first pixel
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            started      <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            if (pop) started <= 1'b1;
            if (started && pix_ready && !pix_valid && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
endmodule
